// File: rtl/step_sequencer_pkg.sv
// Shared encodings for the instruction step sequencer: states, register codes
// and the step numbers that carry special meaning.
package step_sequencer_pkg;

  typedef enum logic [2:0] {
    S_RUN,
    S_STALL,
    S_HALT,
    S_IRQ_SAVE,
    S_IRQ_JUMP
  } state_t;

  localparam logic [3:0] REG_PC        = 4'h0;
  localparam logic [3:0] REG_INTERRUPT = 4'hC;
  localparam logic [3:0] REG_RB3       = 4'hF;

  localparam logic [1:0] STEP_COMMIT = 2'h3;
  localparam logic [1:0] STEP_MEM    = 2'h2;

  function automatic logic is_synthetic(input state_t s);
    return (s == S_IRQ_SAVE) || (s == S_IRQ_JUMP);
  endfunction

endpackage

// File: rtl/step_sequencer_stall_watchdog.sv
// Counts consecutive step-2 wait cycles; fires once the count hits the limit
// and latches a sticky bus_error that only reset clears.
module stall_watchdog #(
  parameter int unsigned STALL_LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic waiting,
  output logic expire,
  output logic bus_error
);

  localparam int unsigned CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0] count;

  // The STALL_LIMIT-th consecutive wait cycle is the one that expires.
  assign expire = waiting && (count == CW'(STALL_LIMIT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      bus_error <= 1'b0;
    end else begin
      if (waiting && !expire) begin
        count <= count + 1'b1;
      end else begin
        count <= '0;
      end
      if (expire) begin
        bus_error <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Four-phase instruction step sequencer: owns commit strobes, memory stall
// stretching, halt and the two-slot synthetic interrupt entry.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int unsigned STALL_LIMIT = 255,
  parameter logic [3:0]  SAVE_REG    = REG_RB3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mem_ready,
  input  logic       halt_req,
  input  logic       resume,
  input  logic       irq,
  input  logic       irq_enable,
  input  logic       irq_return,
  input  logic       dec_write,
  input  logic       dec_push,
  input  logic       dec_pop,
  input  logic       dec_flags,
  output logic [1:0] step,
  output logic       write_enable,
  output logic       inc_enable,
  output logic       write_flags,
  output logic       force_sel,
  output logic [3:0] force_src,
  output logic [3:0] force_dest,
  output logic       irq_active,
  output logic       halted,
  output logic       bus_error,
  output logic       retired
);

  state_t     state, state_next;
  state_t     stall_slot, stall_slot_next;
  state_t     cur_slot;
  logic [1:0] step_next;
  logic       irq_active_next;
  logic       aborted;
  logic       waiting;
  logic       expire;
  logic       irq_take;
  logic       commit;
  logic       synthetic;

  assign waiting  = (step == STEP_MEM) && !mem_ready;
  assign irq_take = irq && irq_enable && !irq_active;

  stall_watchdog #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_watchdog (
    .clock    (clock),
    .reset    (reset),
    .waiting  (waiting),
    .expire   (expire),
    .bus_error(bus_error)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_RUN;
      stall_slot <= S_RUN;
      step       <= 2'd0;
      irq_active <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_next;
      stall_slot <= stall_slot_next;
      step       <= step_next;
      irq_active <= irq_active_next;
      aborted    <= expire;
    end
  end

  always_comb begin
    state_next      = state;
    stall_slot_next = stall_slot;
    step_next       = step;
    irq_active_next = irq_active;
    case (state)
      S_RUN, S_IRQ_SAVE, S_IRQ_JUMP: begin
        if (waiting) begin
          if (expire) begin
            step_next = STEP_COMMIT;
          end else begin
            state_next      = S_STALL;
            stall_slot_next = state;
          end
        end else if (step == STEP_COMMIT) begin
          step_next = 2'd0;
          if (irq_return) begin
            irq_active_next = 1'b0;
          end
          case (state)
            S_IRQ_SAVE: state_next = S_IRQ_JUMP;
            S_IRQ_JUMP: begin
              irq_active_next = 1'b1;
              state_next      = halt_req ? S_HALT : S_RUN;
            end
            default: begin
              if (irq_take) begin
                state_next = S_IRQ_SAVE;
              end else if (halt_req) begin
                state_next = S_HALT;
              end else begin
                state_next = S_RUN;
              end
            end
          endcase
        end else begin
          step_next = step + 2'd1;
        end
      end
      S_STALL: begin
        if (mem_ready || expire) begin
          step_next  = STEP_COMMIT;
          state_next = stall_slot;
        end
      end
      S_HALT: begin
        step_next = 2'd0;
        if (irq_take) begin
          state_next = S_IRQ_SAVE;
        end else if (resume) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_RUN;
        step_next  = 2'd0;
      end
    endcase
  end

  // A stalled slot keeps its forced register selects, so look through STALL.
  assign cur_slot  = (state == S_STALL) ? stall_slot : state;
  assign synthetic = is_synthetic(cur_slot);
  assign commit    = (step == STEP_COMMIT) && !aborted;

  always_comb begin
    force_src  = 4'h0;
    force_dest = 4'h0;
    if (cur_slot == S_IRQ_SAVE) begin
      force_src  = REG_PC;
      force_dest = SAVE_REG;
    end else if (cur_slot == S_IRQ_JUMP) begin
      force_src  = REG_INTERRUPT;
      force_dest = REG_PC;
    end
  end

  assign force_sel    = synthetic;
  assign write_enable = commit && (synthetic || dec_write);
  assign inc_enable   = commit && !synthetic && (dec_push || dec_pop);
  assign write_flags  = commit && !synthetic && dec_flags;
  assign retired      = (step == STEP_COMMIT);
  assign halted       = (state == S_HALT);

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a vector table for plain sequencing and
// halt, then hand sequences for stalls, watchdog, interrupts and async reset.
module tb_step_sequencer;

  typedef struct packed {
    logic mem_ready, halt_req, resume, irq, irq_enable, irq_return;
    logic dec_write, dec_push, dec_pop, dec_flags;
  } in_t;

  typedef struct packed {
    logic [1:0] step;
    logic       we, inc, wf, fsel;
    logic [3:0] src, dst;
    logic       act, halted, berr, ret;
  } out_t;

  typedef struct {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       mem_ready, halt_req, resume, irq, irq_enable, irq_return;
  logic       dec_write, dec_push, dec_pop, dec_flags;
  logic [1:0] step;
  logic       write_enable, inc_enable, write_flags, force_sel;
  logic [3:0] force_src, force_dest;
  logic       irq_active, halted, bus_error, retired;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  step_sequencer #(
    .STALL_LIMIT(6),
    .SAVE_REG   (4'hF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .resume      (resume),
    .irq         (irq),
    .irq_enable  (irq_enable),
    .irq_return  (irq_return),
    .dec_write   (dec_write),
    .dec_push    (dec_push),
    .dec_pop     (dec_pop),
    .dec_flags   (dec_flags),
    .step        (step),
    .write_enable(write_enable),
    .inc_enable  (inc_enable),
    .write_flags (write_flags),
    .force_sel   (force_sel),
    .force_src   (force_src),
    .force_dest  (force_dest),
    .irq_active  (irq_active),
    .halted      (halted),
    .bus_error   (bus_error),
    .retired     (retired)
  );

  // Argument order: mem_ready, halt_req, resume, irq, irq_enable, irq_return,
  // dec_write, dec_push, dec_pop, dec_flags.
  function automatic in_t iv(input logic m, h, r, q, e, x, w, pu, po, f);
    return {m, h, r, q, e, x, w, pu, po, f};
  endfunction

  // Argument order: step, we, inc, wf, fsel, src, dst, act, halted, berr, ret.
  function automatic out_t ov(input logic [1:0] s, input logic we, inc, wf,
                              fsel, input logic [3:0] src, dst,
                              input logic act, hl, be, rt);
    return {s, we, inc, wf, fsel, src, dst, act, hl, be, rt};
  endfunction

  task automatic applyStimulus(input in_t v);
    mem_ready  = v.mem_ready;
    halt_req   = v.halt_req;
    resume     = v.resume;
    irq        = v.irq;
    irq_enable = v.irq_enable;
    irq_return = v.irq_return;
    dec_write  = v.dec_write;
    dec_push   = v.dec_push;
    dec_pop    = v.dec_pop;
    dec_flags  = v.dec_flags;
  endtask

  task automatic checkOutput(input string name, input out_t exp);
    out_t got;
    got = {step, write_enable, inc_enable, write_flags, force_sel, force_src,
           force_dest, irq_active, halted, bus_error, retired};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%b required=%b (step,we,inc,wf,fsel,src,dst,act,halted,berr,ret)",
               name, got, exp);
    end
  endtask

  task automatic runCycle(input string name, input in_t v, input out_t exp);
    @(posedge clock);
    #1;
    applyStimulus(v);
    @(negedge clock);
    checkOutput(name, exp);
  endtask

  // One full unstalled slot, steps 0..3, commit strobes only at step 3.
  task automatic runSlot(input string name, input in_t v, input logic we, inc,
                         wf, fsel, input logic [3:0] src, dst,
                         input logic act, be);
    for (int s = 0; s < 4; s++) begin
      runCycle($sformatf("%s_s%0d", name, s), v,
               ov(2'(s), (s == 3) && we, (s == 3) && inc, (s == 3) && wf,
                  fsel, src, dst, act, 1'b0, be, s == 3));
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t tbl[18];
    in_t  run_w, run_pf, run_pop, wait_m, irq_in, irq_ret;

    run_w   = iv(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    run_pf  = iv(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    run_pop = iv(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    wait_m  = iv(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    tbl[0]  = '{run_w,   ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{run_w,   ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{run_w,   ov(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[3]  = '{run_pf,  ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[4]  = '{run_pf,  ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[5]  = '{run_pf,  ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[6]  = '{run_pf,  ov(3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1)};
    tbl[7]  = '{run_pop, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{run_pop, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[9]  = '{run_pop, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[10] = '{iv(1, 1, 0, 0, 0, 0, 0, 0, 1, 0),
                ov(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1)};
    tbl[11] = '{run_pop, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[12] = '{run_pop, ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[13] = '{iv(1, 0, 1, 0, 0, 0, 0, 0, 1, 0),
                ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
    tbl[14] = '{run_w,   ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{run_w,   ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[16] = '{run_w,   ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[17] = '{run_w,   ov(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)};

    applyStimulus(run_w);
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_state", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      runCycle($sformatf("table_%0d", i), tbl[i].stim, tbl[i].exp);
    end

    // Five wait cycles at step 2 then ready: six step-2 cycles, one commit.
    runCycle("stall_s0", run_w, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle("stall_s1", run_w, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      runCycle($sformatf("stall_wait%0d", i), wait_m,
               ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    runCycle("stall_ready", run_w, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle("stall_commit", run_w, ov(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    runCycle("stall_next", run_w, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Six consecutive waits reach the limit of 6: aborted commit, sticky error.
    runCycle("wd_s1", run_w, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      runCycle($sformatf("wd_wait%0d", i), wait_m,
               ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    runCycle("wd_abort", run_w, ov(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    runSlot("wd_after", run_w, 1, 0, 0, 0, 4'h0, 4'h0, 0, 1);

    // Interrupt raised mid-instruction, held high to show no nesting.
    irq_in  = iv(1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
    runSlot("irq_cur", irq_in, 1, 0, 0, 0, 4'h0, 4'h0, 0, 1);
    irq_in  = iv(1, 0, 0, 1, 1, 0, 0, 1, 0, 1);
    runSlot("irq_save", irq_in, 1, 0, 0, 1, 4'h0, 4'hF, 0, 1);
    runSlot("irq_jump", irq_in, 1, 0, 0, 1, 4'hC, 4'h0, 0, 1);
    runSlot("irq_ignored", irq_in, 0, 1, 1, 0, 4'h0, 4'h0, 1, 1);
    irq_ret = iv(1, 0, 0, 1, 1, 1, 0, 1, 0, 1);
    runSlot("irq_ret", irq_ret, 0, 1, 1, 0, 4'h0, 4'h0, 1, 1);
    runCycle("irq_cleared", run_w, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    runCycle("irq_cleared_s1", run_w, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    runCycle("irq_cleared_s2", run_w, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Halt and irq together at step 3: interrupt first, halt after the jump.
    runCycle("hi_commit", iv(1, 1, 0, 1, 1, 0, 1, 0, 0, 0),
             ov(3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    runSlot("hi_save", iv(1, 1, 0, 0, 1, 0, 1, 0, 0, 0),
            1, 0, 0, 1, 4'h0, 4'hF, 0, 1);
    runSlot("hi_jump", iv(1, 1, 0, 0, 1, 0, 1, 0, 0, 0),
            1, 0, 0, 1, 4'hC, 4'h0, 0, 1);
    runCycle("hi_halted", run_w, ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    runCycle("hi_resume", iv(1, 0, 1, 0, 0, 0, 1, 0, 0, 0),
             ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    runCycle("hi_run", run_w, ov(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    runCycle("hi_run_s1", run_w, ov(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));

    // Async reset while stalled at step 2, with no clock edge in between.
    runCycle("rst_wait0", wait_m, ov(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    runCycle("rst_wait1", wait_m, ov(2, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_async", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    applyStimulus(run_w);
    @(negedge clock);
    checkOutput("rst_release", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle("rst_s1", run_w, ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle("rst_s2", run_w, ov(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle("rst_s3", run_w, ov(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
